sync_4phase: RTL and testbench
==============================

# sync_4phase

Single-clock four-phase (req/ack) data transfer channel with two-flop synchronizers on both handshake directions. It carries `indata` words from a transmit side to a receive side. A small transmit queue absorbs back-to-back `vi` strobes. It sits between a data producer and a consumer and is the template for a later clock-domain-crossing variant, so all handshake signals are synchronized even though both sides share one clock.

## Interface
Parameters:
- `DATA_MSB`, default 31: MSB index of the data path (width = `DATA_MSB+1`).
- `FIFO_DEPTH`, default 4: transmit queue entries (power of two, ≥2). Used only with `SYNC_TX_FIFO_EN`.

Ports:
- `clk_tx`  in  1  The single clock, rising edge. Both the tx and rx sides use it.
- `reset`  in  1  Asynchronous, active-low reset.
- `vi`  in  1  Input valid. `indata` is accepted on every rising edge where `vi`=1.
- `indata`  in  DATA_MSB+1  Word to send.
- `rdata`  out  DATA_MSB+1  Last received word. Holds its value between transfers.
- `vo`  out  1  One-cycle pulse. `rdata` was updated on this cycle.
- `snt`  out  1  One-cycle pulse. The transmitter received ack for the current word.

## Operation
- Tx FSM has three states: `IDLE`, `WAIT_ACK_HI`, `WAIT_ACK_LO`.
  - In `IDLE` with the queue non-empty: pop the head word into `tx_data`, set `req`=1, go to `WAIT_ACK_HI`.
  - In `WAIT_ACK_HI`: when `ack_s2`=1, set `req`=0, pulse `snt`, go to `WAIT_ACK_LO`.
  - In `WAIT_ACK_LO`: when `ack_s2`=0, go to `IDLE`.
- `tx_data` is stable whenever `req`=1 (bundled data). The rx side samples it directly.
- `req` passes through a 2-flop synchronizer (`req_s1`, `req_s2`). `ack` passes through a 2-flop synchronizer (`ack_s1`, `ack_s2`).
- Rx side behaviour:
  - When `req_s2`=1 and `ack`=0: `rdata`<=`tx_data`, `vo`<=1 for one cycle, `ack`<=1.
  - When `req_s2`=0 and `ack`=1: `ack`<=0.
- Queue behaviour:
  - A write with `vi`=1 while the queue is full is silently dropped.
  - A write and a pop in the same cycle are both performed, even when the queue is full.
  - Words leave in arrival order.
- Reset may arrive mid-transfer. It asynchronously clears the FSM, `req`, `ack`, all synchronizer flops, the queue pointers, `rdata`, `vo` and `snt`. No partial word is delivered.
- Reset values: `rdata`=0, `vo`=0, `snt`=0.

## Timing
Word written at edge 0, with an empty queue and the FSM in `IDLE`:
- Edge 1: `req`=1.
- Edges 2 and 3: `req_s1`, then `req_s2`.
- Edge 4: `rdata` valid, `vo`=1, `ack`=1.
- Edges 5 and 6: `ack_s1`, then `ack_s2`.
- Edge 7: `req`=0, `snt`=1.
- Edge 10: `ack`=0.
- Edge 13: FSM returns to `IDLE`.
- Edge 14: next `req` rises, if the queue is non-empty.

Summary figures:
- `vi`→`vo` latency: 4 cycles.
- Full handshake period: 13 cycles.
- Sustained throughput: 1 word per 13 cycles.
- `vo` and `snt` are never high for two consecutive cycles.

## Configuration
- `SYNC_TX_FIFO_EN` defined: the transmit queue is a `FIFO_DEPTH`-entry circular buffer with wrap-around read and write pointers plus a count.
- `SYNC_TX_FIFO_EN` undefined: the queue is a single holding register with a valid bit.
  - `vi` while the holding register is valid is dropped.
  - The holding register is freed at the `IDLE`→`WAIT_ACK_HI` load.

## Test plan
- Reset released, no `vi`: `rdata`=0, `vo`=0, `snt`=0 indefinitely.
- Single word 0xDEADBEEF at edge 0: `vo`=1 at edge 4 with `rdata`=0xDEADBEEF; `snt`=1 at edge 7; `rdata` still 0xDEADBEEF at edge 40.
- Four words A, B, C, D with `vi` pulses 2 cycles apart, `SYNC_TX_FIFO_EN` on: four `vo` pulses 13 cycles apart deliver A, B, C, D in order; four `snt` pulses.
- Same stimulus, `SYNC_TX_FIFO_EN` off: only A and B are delivered; C and D are dropped.
- Six words while the FIFO (depth 4) fills during the first transfer: the first five are delivered (one in flight plus four queued); the sixth is dropped.
- `reset` asserted at edge 5 of a transfer: all outputs become 0 immediately; after release, no `vo` or `snt` occurs without a new `vi`.

Source files
------------

// File: rtl/sync_4phase.sv
// Four-phase req/ack word channel with two-flop synchronizers on req and ack, fed by a transmit queue.
// Define SYNC_TX_FIFO_EN for a FIFO_DEPTH-entry circular queue; otherwise a single holding register is used.
module sync_4phase #(
    parameter int DATA_MSB   = 31,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_tx,
    input  logic              reset,
    input  logic              vi,
    input  logic [DATA_MSB:0] indata,
    output logic [DATA_MSB:0] rdata,
    output logic              vo,
    output logic              snt
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } tx_state_t;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    tx_state_t         state_reg, state_next;
    logic              req_reg, req_next;
    logic              snt_next;
    logic              pop;
    logic              wr;
    logic              empty;
    logic              full;
    logic [DATA_MSB:0] head_data;
    logic [DATA_MSB:0] tx_data_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              req_s1, req_s2;
    logic              ack_s1, ack_s2;
    logic              ack_reg;

    // A write in the same cycle as a pop always fits, even when the queue was full.
    assign wr = vi && (!full || pop);

`ifdef SYNC_TX_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_MSB:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;

    always_ff @(posedge clk_tx) begin
        if (wr) begin
            mem[wr_ptr_reg] <= indata;
        end
    end

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (wr && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!wr && pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
`else
    logic [DATA_MSB:0] hold_data_reg;

    always_ff @(posedge clk_tx) begin
        if (wr) begin
            hold_data_reg <= indata;
        end
    end

    // Occupancy is 0 or 1 here: the counter doubles as the holding register's valid bit.
    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (wr) begin
            count_reg <= CNT_W'(1);
        end else if (pop) begin
            count_reg <= '0;
        end
    end

    assign head_data = hold_data_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg != '0);
`endif

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        snt_next   = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    req_next   = 1'b1;
                    state_next = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (ack_s2) begin
                    req_next   = 1'b0;
                    snt_next   = 1'b1;
                    state_next = WAIT_ACK_LO;
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_s2) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            snt       <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            snt       <= snt_next;
        end
    end

    // Bundled data: only changes on a pop, and req is low whenever a pop happens.
    always_ff @(posedge clk_tx) begin
        if (pop) begin
            tx_data_reg <= head_data;
        end
    end

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            req_s1 <= req_reg;
            req_s2 <= req_s1;
            ack_s1 <= ack_reg;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            ack_reg <= 1'b0;
            rdata   <= '0;
            vo      <= 1'b0;
        end else begin
            vo <= 1'b0;
            if (req_s2 && !ack_reg) begin
                rdata   <= tx_data_reg;
                vo      <= 1'b1;
                ack_reg <= 1'b1;
            end else if (!req_s2 && ack_reg) begin
                ack_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_4phase.sv
// Bench for sync_4phase: directed and random vi traffic checked every cycle against a
// transfer-timeline model (pop at p => vo at p+3, snt at p+6, next pop no earlier than p+13).
module tb_sync_4phase;

`ifdef SYNC_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk_tx;
    logic        reset;
    logic        vi;
    logic [31:0] indata;
    logic [31:0] rdata;
    logic        vo;
    logic        snt;

    int tests;
    int failed;

    sync_4phase #(
        .DATA_MSB  (31),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_tx(clk_tx),
        .reset (reset),
        .vi    (vi),
        .indata(indata),
        .rdata (rdata),
        .vo    (vo),
        .snt   (snt)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    // Reference model state
    logic [31:0] q[$];
    int          edge_n;
    int          idle_from;
    int          vo_edge;
    int          snt_edge;
    logic [31:0] vo_word;
    logic [31:0] exp_rdata;
    logic        exp_vo;
    logic        exp_snt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s at edge %0d: got 0x%08h, expected 0x%08h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        edge_n    = 0;
        idle_from = 0;
        vo_edge   = -1000;
        snt_edge  = -1000;
        vo_word   = '0;
        exp_rdata = '0;
        exp_vo    = 1'b0;
        exp_snt   = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d);
        if (edge_n >= idle_from && q.size() > 0) begin
            vo_word   = q.pop_front();
            vo_edge   = edge_n + 3;
            snt_edge  = edge_n + 6;
            idle_from = edge_n + 13;
        end
        if (v && q.size() < CAP) begin
            q.push_back(d);
        end
        exp_vo  = (edge_n == vo_edge);
        exp_snt = (edge_n == snt_edge);
        if (exp_vo) begin
            exp_rdata = vo_word;
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] d);
        vi     = v;
        indata = d;
        @(posedge clk_tx);
        model_edge(v, d);
        @(negedge clk_tx);
        check("vo", {31'd0, vo}, {31'd0, exp_vo});
        check("snt", {31'd0, snt}, {31'd0, exp_snt});
        check("rdata", rdata, exp_rdata);
        if (vo === 1'b1) begin
            $display("[TB] edge %0d rx word 0x%08h", edge_n, rdata);
        end
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 32'h0);
        end
    endtask

    task automatic burst(input int n, input int gap, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, base + 32'(i));
            for (int j = 1; j < gap; j++) begin
                cycle(1'b0, 32'h0);
            end
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        vi     = 1'b0;
        indata = '0;
        model_reset();

        repeat (2) @(posedge clk_tx);
        @(negedge clk_tx);
        check("rst_rdata", rdata, 32'h0);
        check("rst_vo", {31'd0, vo}, 32'h0);
        check("rst_snt", {31'd0, snt}, 32'h0);
        reset = 1'b1;

        idle(12);
        edge_n = 0;
        idle_from = 0;

        // Single word: vo at edge 4, snt at edge 7, rdata held through edge 40
        cycle(1'b1, 32'hDEADBEEF);
        idle(40);
        check("hold_rdata", rdata, 32'hDEADBEEF);

        // Four words two cycles apart
        burst(4, 2, 32'hA0A0_0000);
        idle(60);

        // Six back-to-back words: fills the queue during the first transfer
        burst(6, 1, 32'h6000_0000);
        idle(90);

        // Reset just before edge 5 of a transfer, with a second word queued
        cycle(1'b1, 32'h1234_5678);
        cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h8765_4321);
        idle(2);
        check("pre_rst_vo", {31'd0, vo}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rdata", rdata, 32'h0);
        check("async_vo", {31'd0, vo}, 32'h0);
        check("async_snt", {31'd0, snt}, 32'h0);
        @(posedge clk_tx);
        @(negedge clk_tx);
        reset = 1'b1;
        model_reset();
        idle(30);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 5) == 0), $urandom);
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
